// File: rtl/debounce_pkg.sv
// Shared types for the button debounce / press pulse generator.
// State encoding and press counter width.
package debounce_pkg;

  localparam int PRESS_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_HI  = 2'd1,
    PRESSED = 2'd2,
    ARM_LO  = 2'd3
  } db_state_t;

endpackage

// File: rtl/debounce_pulse_gen_if.sv
// Button-side and counter-side signals of the debounce block.
// master drives the raw button, slave is the debounce block.
interface debounce_pulse_gen_if;
  import debounce_pkg::*;

  logic               btn;
  logic               pulse;
  logic               level;
  logic [PRESS_W-1:0] presses;

  modport master (
    output btn,
    input  pulse,
    input  level,
    input  presses
  );

  modport slave (
    input  btn,
    output pulse,
    output level,
    output presses
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Synchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_pulse_gen.sv
// Debounces a raw push-button and emits one pulse per accepted press.
// Also keeps a wrapping count of accepted presses.
module debounce_pulse_gen
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input logic                 clk,
  input logic                 reset,
  debounce_pulse_gen_if.slave bus
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  db_state_t          state;
  db_state_t          state_n;
  logic [7:0]         cnt;
  logic [7:0]         cnt_n;
  logic [7:0]         cnt_inc;
  logic               s2;
  logic               hit;
  logic               rise;
  logic               pulse;
  logic               level;
  logic [PRESS_W-1:0] presses;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn),
    .q     (s2)
  );

  assign cnt_inc = cnt + 8'd1;
  assign hit     = (cnt_inc >= STABLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (s2) begin
          if (STABLE == 8'd1) begin
            state_n = PRESSED;
            cnt_n   = 8'd0;
          end else begin
            state_n = ARM_HI;
            cnt_n   = 8'd1;
          end
        end
      end
      ARM_HI: begin
        if (!s2) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else if (hit) begin
          state_n = PRESSED;
          cnt_n   = 8'd0;
        end else begin
          cnt_n   = cnt_inc;
        end
      end
      PRESSED: begin
        if (!s2) begin
          if (STABLE == 8'd1) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
          end else begin
            state_n = ARM_LO;
            cnt_n   = 8'd1;
          end
        end
      end
      ARM_LO: begin
        if (s2) begin
          state_n = PRESSED;
          cnt_n   = 8'd0;
        end else if (hit) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n   = cnt_inc;
        end
      end
    endcase
  end

  // Only a press pulses; falling back into PRESSED from ARM_LO is release bounce.
  assign rise = (state_n == PRESSED)
             && ((state == IDLE) || (state == ARM_HI));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      pulse   <= 1'b0;
      level   <= 1'b0;
      presses <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pulse <= rise;
      level <= (state_n == PRESSED) || (state_n == ARM_LO);
      if (rise) presses <= presses + 1'b1;
    end
  end

  assign bus.pulse   = pulse;
  assign bus.level   = level;
  assign bus.presses = presses;

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Bench for debounce_pulse_gen: STABLE_CYCLES=4 and =1 builds share one button.
// A run-length model of the debouncer is compared every cycle.
module tb_debounce_pulse_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn = 1'b0;
  logic armed = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  debounce_pulse_gen_if bus0 ();
  debounce_pulse_gen_if bus1 ();

  assign bus0.btn = btn;
  assign bus1.btn = btn;

  debounce_pulse_gen #(.STABLE_CYCLES(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  debounce_pulse_gen #(.STABLE_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  logic       p [2];
  logic       l [2];
  logic [4:0] c [2];

  assign p[0] = bus0.pulse;
  assign l[0] = bus0.level;
  assign c[0] = bus0.presses;
  assign p[1] = bus1.pulse;
  assign l[1] = bus1.level;
  assign c[1] = bus1.presses;

  function automatic int stab(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: debounced level flips after stab() consecutive synchronized
  // samples that disagree with it; a flip to 1 is a press.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_level [2];
  logic m_pulse [2];
  int   m_run [2];
  int   m_presses [2];

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_level[i] = 1'b0;
        m_pulse[i] = 1'b0;
        m_run[i] = 0;
        m_presses[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] = 1'b0;
        if (m_s2 != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == stab(i)) begin
            m_level[i] = ~m_level[i];
            m_run[i] = 0;
            if (m_level[i]) begin
              m_pulse[i] = 1'b1;
              m_presses[i] = (m_presses[i] + 1) % 32;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  int npulse [2] = '{0, 0};

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("pulse[%0d]", i), int'(p[i]), int'(m_pulse[i]));
        chk($sformatf("level[%0d]", i), int'(l[i]), int'(m_level[i]));
        chk($sformatf("presses[%0d]", i), int'(c[i]), m_presses[i]);
        if (p[i] === 1'b1) npulse[i]++;
      end
    end
  end

  task automatic tick(input logic b, input logic r);
    btn = b;
    reset = r;
    @(posedge clk);
    #2;
  endtask

  int base;
  int runleft;
  logic rb;

  initial begin
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    armed = 1'b1;
    chk("reset_pulse", int'(p[0]), 0);
    chk("reset_level", int'(l[0]), 0);
    chk("reset_presses", int'(c[0]), 0);

    // Clean press: first edge sampling 1 is edge e
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    base = npulse[0];
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("s1_pulse_e2", int'(p[1]), 1);
    chk("s1_presses_e2", int'(c[1]), 1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("clean_level_e4", int'(l[0]), 0);
    tick(1'b1, 1'b0);
    chk("clean_pulse_e5", int'(p[0]), 1);
    chk("clean_presses_e5", int'(c[0]), 1);
    repeat (14) tick(1'b1, 1'b0);
    chk("clean_one_pulse", npulse[0] - base, 1);
    chk("clean_level_held", int'(l[0]), 1);

    // Release bounce
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    repeat (8) tick(1'b1, 1'b0);
    chk("relbounce_level", int'(l[0]), 1);
    chk("relbounce_presses", int'(c[0]), 1);
    repeat (8) tick(1'b0, 1'b0);
    chk("release_level", int'(l[0]), 0);

    // Press bounce filter
    base = npulse[0];
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    repeat (10) tick(1'b1, 1'b0);
    chk("bounce_one_pulse", npulse[0] - base, 1);
    chk("bounce_presses", int'(c[0]), 2);
    repeat (8) tick(1'b0, 1'b0);

    // Reset mid-press
    base = npulse[0];
    repeat (3) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("midrst_pulse", int'(p[0]), 0);
    chk("midrst_level", int'(l[0]), 0);
    chk("midrst_presses", int'(c[0]), 0);
    repeat (10) tick(1'b1, 1'b0);
    chk("midrst_one_pulse", npulse[0] - base, 1);
    chk("midrst_presses_after", int'(c[0]), 1);
    repeat (8) tick(1'b0, 1'b0);

    // Wrap-around over 33 presses
    tick(1'b0, 1'b1);
    base = npulse[0];
    for (int n = 1; n <= 33; n++) begin
      repeat (7) tick(1'b1, 1'b0);
      repeat (7) tick(1'b0, 1'b0);
      if (n == 31) chk("wrap_31", int'(c[0]), 31);
      if (n == 32) chk("wrap_32", int'(c[0]), 0);
      if (n == 33) chk("wrap_33", int'(c[0]), 1);
    end
    chk("wrap_pulses", npulse[0] - base, 33);

    // Random bouncing with occasional reset
    runleft = 0;
    rb = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (runleft == 0) begin
        rb = 1'($urandom_range(0, 1));
        runleft = $urandom_range(1, 9);
      end
      runleft--;
      tick(rb, ($urandom_range(0, 299) == 0));
    end
    tick(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
